// File: rtl/queue_retire_tracker.sv
// queue_retire_tracker: in-order retire tracking for a queue with out-of-order completions.
module queue_retire_tracker #(
   parameter int Depth       = 8,
   parameter int AllocWidth  = 2,
   parameter int CplWidth    = 2,
   parameter int RetireWidth = 2
) (
   input  logic                                      clk,
   input  logic                                      rstn,
   input  logic [AllocWidth-1:0]                     alloc_vld_i,
   output logic                                      alloc_rdy_o,
   output logic [AllocWidth-1:0][$clog2(Depth):0]    alloc_tag_o,
   input  logic [CplWidth-1:0]                       cpl_vld_i,
   input  logic [CplWidth-1:0][$clog2(Depth):0]      cpl_tag_i,
   output logic [RetireWidth-1:0]                    retire_vld_o,
   output logic [RetireWidth-1:0][$clog2(Depth):0]   retire_tag_o,
   input  logic                                      retire_rdy_i,
   input  logic                                      flush_i,
   output logic [$clog2(Depth+1)-1:0]                count_o,
   output logic                                      empty_o,
   output logic                                      full_o
);
   localparam int PW = $clog2(Depth);
   localparam int TW = PW + 1;
   localparam int CW = $clog2(Depth+1);
   logic [Depth-1:0] alloc_q, done_q, flag_q, alloc_d, done_d, flag_d;
   logic [TW-1:0] head_q, tail_q, head_d, tail_d;
   logic [CW-1:0] count_q, count_d, nalloc, nretire;
   logic [AllocWidth-1:0] alloc_fire;
   logic ok;
   function automatic logic [TW-1:0] adv(input logic [TW-1:0] t, input logic [CW-1:0] n);
      logic [PW+1:0] s;
      s = (PW+2)'(t[PW-1:0]) + (PW+2)'(n);
      return s >= (PW+2)'(Depth) ? {~t[PW], PW'(s - (PW+2)'(Depth))} : {t[PW], PW'(s)};
   endfunction
   assign alloc_rdy_o = count_q <= CW'(Depth - AllocWidth);
   assign alloc_fire  = alloc_vld_i & {AllocWidth{alloc_rdy_o & ~flush_i}};
   assign count_o     = count_q;
   assign empty_o     = count_q == '0;
   assign full_o      = count_q == CW'(Depth);
   always_comb begin
      ok = 1'b1;
      for (int i = 0; i < AllocWidth; i++) alloc_tag_o[i] = adv(tail_q, CW'(i));
      for (int i = 0; i < RetireWidth; i++) begin
         retire_tag_o[i] = adv(head_q, CW'(i));
         ok = ok & alloc_q[retire_tag_o[i][PW-1:0]] & done_q[retire_tag_o[i][PW-1:0]];
         retire_vld_o[i] = ok & (CW'(i) < count_q) & ~flush_i;
      end
   end
   always_comb begin
      alloc_d = alloc_q;
      done_d  = done_q;
      flag_d  = flag_q;
      nalloc  = '0;
      nretire = '0;
      for (int i = 0; i < AllocWidth; i++) nalloc = nalloc + CW'(alloc_fire[i]);
      for (int i = 0; i < RetireWidth; i++) nretire = nretire + CW'(retire_vld_o[i] & retire_rdy_i);
      for (int i = 0; i < CplWidth; i++)
         if (cpl_vld_i[i] && int'(cpl_tag_i[i][PW-1:0]) < Depth && alloc_q[cpl_tag_i[i][PW-1:0]] &&
             flag_q[cpl_tag_i[i][PW-1:0]] == cpl_tag_i[i][PW])
            done_d[cpl_tag_i[i][PW-1:0]] = 1'b1;
      for (int i = 0; i < RetireWidth; i++)
         if (retire_vld_o[i] && retire_rdy_i) begin
            alloc_d[retire_tag_o[i][PW-1:0]] = 1'b0;
            done_d[retire_tag_o[i][PW-1:0]]  = 1'b0;
         end
      for (int i = 0; i < AllocWidth; i++)
         if (alloc_fire[i]) begin
            alloc_d[alloc_tag_o[i][PW-1:0]] = 1'b1;
            done_d[alloc_tag_o[i][PW-1:0]]  = 1'b0;
            flag_d[alloc_tag_o[i][PW-1:0]]  = alloc_tag_o[i][PW];
         end
      head_d  = adv(head_q, nretire);
      tail_d  = adv(tail_q, nalloc);
      count_d = count_q + nalloc - nretire;
      if (flush_i) begin
         alloc_d = '0;
         done_d  = '0;
         head_d  = tail_q;
         tail_d  = tail_q;
         count_d = '0;
      end
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         alloc_q <= '0;
         done_q  <= '0;
         flag_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         alloc_q <= alloc_d;
         done_q  <= done_d;
         flag_q  <= flag_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
endmodule

// File: tb/tb_queue_retire_tracker.sv
// tb_queue_retire_tracker: directed checks on Depth=8 and Depth=6 instances.
module tb_queue_retire_tracker;
   logic clk = 1'b0, rstn = 1'b0;
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   logic [1:0] a8_vld, c8_vld, r8_vld, a6_vld, c6_vld, r6_vld;
   logic a8_rdy, r8_rdy, f8, e8, fu8, a6_rdy, r6_rdy, f6, e6, fu6;
   logic [1:0][3:0] a8_tag, c8_tag, r8_tag, a6_tag, c6_tag, r6_tag;
   logic [3:0] cnt8;
   logic [2:0] cnt6;
   queue_retire_tracker #(.Depth(8), .AllocWidth(2), .CplWidth(2), .RetireWidth(2)) d8 (
      .clk(clk), .rstn(rstn), .alloc_vld_i(a8_vld), .alloc_rdy_o(a8_rdy), .alloc_tag_o(a8_tag),
      .cpl_vld_i(c8_vld), .cpl_tag_i(c8_tag), .retire_vld_o(r8_vld), .retire_tag_o(r8_tag),
      .retire_rdy_i(r8_rdy), .flush_i(f8), .count_o(cnt8), .empty_o(e8), .full_o(fu8));
   queue_retire_tracker #(.Depth(6), .AllocWidth(2), .CplWidth(2), .RetireWidth(2)) d6 (
      .clk(clk), .rstn(rstn), .alloc_vld_i(a6_vld), .alloc_rdy_o(a6_rdy), .alloc_tag_o(a6_tag),
      .cpl_vld_i(c6_vld), .cpl_tag_i(c6_tag), .retire_vld_o(r6_vld), .retire_tag_o(r6_tag),
      .retire_rdy_i(r6_rdy), .flush_i(f6), .count_o(cnt6), .empty_o(e6), .full_o(fu6));
   task automatic idle();
      a8_vld = '0; c8_vld = '0; c8_tag = '0; r8_rdy = 1'b0; f8 = 1'b0;
      a6_vld = '0; c6_vld = '0; c6_tag = '0; r6_rdy = 1'b0; f6 = 1'b0;
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask
   task automatic test_reset();
      #2;
      checks++; if ({cnt8, e8, fu8, a8_rdy} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin errors++; $display("FAIL reset_status got %h exp %h", {cnt8, e8, fu8, a8_rdy}, {4'd0, 3'b101}); end
      checks++; if ({a8_tag, r8_tag, r8_vld} !== {8'h10, 8'h10, 2'b00}) begin errors++; $display("FAIL reset_tags got %h exp %h", {a8_tag, r8_tag, r8_vld}, {8'h10, 8'h10, 2'b00}); end
      @(posedge clk); @(posedge clk); #1;
      rstn = 1'b1;
      cyc();
      checks++; if ({cnt8, e8, a8_rdy, a8_tag, r8_vld} !== {4'd0, 1'b1, 1'b1, 8'h10, 2'b00}) begin errors++; $display("FAIL idle_state got %h", {cnt8, e8, a8_rdy, a8_tag, r8_vld}); end
      checks++; if ({cnt6, e6, a6_rdy, a6_tag, r6_tag} !== {3'd0, 1'b1, 1'b1, 8'h10, 8'h10}) begin errors++; $display("FAIL idle_state6 got %h", {cnt6, e6, a6_rdy, a6_tag, r6_tag}); end
   endtask
   task automatic test_fill();
      for (int k = 0; k < 4; k++) begin
         checks++; if (a8_tag !== {4'(2*k+1), 4'(2*k)}) begin errors++; $display("FAIL fill_tag%0d got %h exp %h", k, a8_tag, {4'(2*k+1), 4'(2*k)}); end
         a8_vld = 2'b11;
         cyc();
      end
      checks++; if ({cnt8, fu8, a8_rdy, e8} !== {4'd8, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL full_status got %h exp %h", {cnt8, fu8, a8_rdy, e8}, {4'd8, 3'b100}); end
      a8_vld = 2'b11;
      cyc();
      checks++; if ({cnt8, a8_tag} !== {4'd8, 8'h98}) begin errors++; $display("FAIL full_ignore got %h exp %h", {cnt8, a8_tag}, {4'd8, 8'h98}); end
   endtask
   task automatic test_order();
      c8_vld = 2'b11; c8_tag = {4'd1, 4'd3};
      cyc();
      checks++; if (r8_vld !== 2'b00) begin errors++; $display("FAIL order_hold got %b exp 00", r8_vld); end
      c8_vld = 2'b01; c8_tag[0] = 4'd0;
      cyc();
      checks++; if ({r8_vld, r8_tag} !== {2'b11, 8'h10}) begin errors++; $display("FAIL order_ret01 got %h exp %h", {r8_vld, r8_tag}, {2'b11, 8'h10}); end
      r8_rdy = 1'b1;
      cyc();
      checks++; if ({r8_vld, cnt8, r8_tag} !== {2'b00, 4'd6, 8'h32}) begin errors++; $display("FAIL order_gap got %h exp %h", {r8_vld, cnt8, r8_tag}, {2'b00, 4'd6, 8'h32}); end
      c8_vld = 2'b01; c8_tag[0] = 4'd2;
      cyc();
      checks++; if ({r8_vld, r8_tag} !== {2'b11, 8'h32}) begin errors++; $display("FAIL order_ret23 got %h exp %h", {r8_vld, r8_tag}, {2'b11, 8'h32}); end
      r8_rdy = 1'b1;
      cyc();
      checks++; if ({cnt8, a8_rdy} !== {4'd4, 1'b1}) begin errors++; $display("FAIL order_count got %h exp %h", {cnt8, a8_rdy}, {4'd4, 1'b1}); end
   endtask
   task automatic test_wrap();
      c8_vld = 2'b11; c8_tag = {4'd5, 4'd4};
      cyc();
      c8_vld = 2'b11; c8_tag = {4'd7, 4'd6};
      cyc();
      for (int k = 0; k < 6; k++) begin
         checks++; if ({a8_tag[0], r8_vld, r8_tag[0], cnt8} !== {4'(8+2*k), 2'b11, 4'(4+2*k), 4'd4})
            begin errors++; $display("FAIL wrap_step%0d got %h exp %h", k, {a8_tag[0], r8_vld, r8_tag[0], cnt8}, {4'(8+2*k), 2'b11, 4'(4+2*k), 4'd4}); end
         a8_vld = 2'b11; r8_rdy = 1'b1;
         if (k > 0) begin c8_vld = 2'b11; c8_tag = {4'(7+2*k), 4'(6+2*k)}; end
         cyc();
      end
      checks++; if ({cnt8, r8_vld, r8_tag} !== {4'd4, 2'b11, 8'h10}) begin errors++; $display("FAIL wrap_end got %h exp %h", {cnt8, r8_vld, r8_tag}, {4'd4, 2'b11, 8'h10}); end
      c8_vld = 2'b11; c8_tag = {4'd11, 4'd10}; r8_rdy = 1'b1;
      cyc();
      checks++; if ({r8_vld, cnt8, r8_tag} !== {2'b00, 4'd2, 8'h32}) begin errors++; $display("FAIL stale_cpl got %h exp %h", {r8_vld, cnt8, r8_tag}, {2'b00, 4'd2, 8'h32}); end
      c8_vld = 2'b11; c8_tag = {4'd2, 4'd2};
      cyc();
      checks++; if (r8_vld !== 2'b01) begin errors++; $display("FAIL dup_cpl got %b exp 01", r8_vld); end
      c8_vld = 2'b01; c8_tag[0] = 4'd3;
      cyc();
      checks++; if (r8_vld !== 2'b11) begin errors++; $display("FAIL cpl3 got %b exp 11", r8_vld); end
      r8_rdy = 1'b1;
      cyc();
      checks++; if ({cnt8, e8, a8_tag[0], r8_tag[0]} !== {4'd0, 1'b1, 4'd4, 4'd4}) begin errors++; $display("FAIL drain got %h exp %h", {cnt8, e8, a8_tag[0], r8_tag[0]}, {4'd0, 1'b1, 8'h44}); end
   endtask
   task automatic test_flush();
      a8_vld = 2'b11; cyc();
      a8_vld = 2'b11; cyc();
      a8_vld = 2'b01; cyc();
      c8_vld = 2'b01; c8_tag[0] = 4'd4;
      cyc();
      checks++; if ({cnt8, r8_vld} !== {4'd5, 2'b01}) begin errors++; $display("FAIL pre_flush got %h exp %h", {cnt8, r8_vld}, {4'd5, 2'b01}); end
      f8 = 1'b1; c8_vld = 2'b01; c8_tag[0] = 4'd5; r8_rdy = 1'b1; a8_vld = 2'b11;
      #1;
      checks++; if (r8_vld !== 2'b00) begin errors++; $display("FAIL flush_gate got %b exp 00", r8_vld); end
      cyc();
      checks++; if ({cnt8, e8, r8_vld, a8_tag[0], r8_tag[0]} !== {4'd0, 1'b1, 2'b00, 4'd9, 4'd9}) begin errors++; $display("FAIL post_flush got %h exp %h", {cnt8, e8, r8_vld, a8_tag[0], r8_tag[0]}, {4'd0, 1'b1, 2'b00, 8'h99}); end
      a8_vld = 2'b01;
      cyc();
      checks++; if ({cnt8, r8_vld, r8_tag[0], a8_tag[0]} !== {4'd1, 2'b00, 4'd9, 4'd10}) begin errors++; $display("FAIL flush_alloc got %h exp %h", {cnt8, r8_vld, r8_tag[0], a8_tag[0]}, {4'd1, 2'b00, 8'h9a}); end
      c8_vld = 2'b01; c8_tag[0] = 4'd9;
      cyc();
      checks++; if (r8_vld !== 2'b01) begin errors++; $display("FAIL flush_cpl got %b exp 01", r8_vld); end
   endtask
   task automatic test_depth6();
      for (int k = 0; k < 3; k++) begin
         checks++; if (a6_tag !== {4'(2*k+1), 4'(2*k)}) begin errors++; $display("FAIL d6_tag%0d got %h exp %h", k, a6_tag, {4'(2*k+1), 4'(2*k)}); end
         a6_vld = 2'b11;
         cyc();
      end
      checks++; if ({cnt6, fu6, a6_rdy, a6_tag} !== {3'd6, 1'b1, 1'b0, 8'h98}) begin errors++; $display("FAIL d6_full got %h exp %h", {cnt6, fu6, a6_rdy, a6_tag}, {3'd6, 2'b10, 8'h98}); end
      c6_vld = 2'b11; c6_tag = {4'd1, 4'd0}; cyc();
      c6_vld = 2'b11; c6_tag = {4'd3, 4'd2}; cyc();
      r6_rdy = 1'b1; cyc();
      checks++; if ({cnt6, a6_rdy, r6_vld, r6_tag} !== {3'd4, 1'b1, 2'b11, 8'h32}) begin errors++; $display("FAIL d6_ret got %h exp %h", {cnt6, a6_rdy, r6_vld, r6_tag}, {3'd4, 3'b111, 8'h32}); end
      a6_vld = 2'b11; r6_rdy = 1'b1;
      cyc();
      checks++; if ({cnt6, a6_tag[0], r6_tag, r6_vld} !== {3'd4, 4'd10, 8'h54, 2'b00}) begin errors++; $display("FAIL d6_both got %h exp %h", {cnt6, a6_tag[0], r6_tag, r6_vld}, {3'd4, 4'd10, 8'h54, 2'b00}); end
      c6_vld = 2'b11; c6_tag = {4'd5, 4'd4};
      cyc();
      checks++; if (r6_vld !== 2'b11) begin errors++; $display("FAIL d6_cpl got %b exp 11", r6_vld); end
      r6_rdy = 1'b1;
      cyc();
      checks++; if ({cnt6, r6_tag, r6_vld} !== {3'd2, 8'h98, 2'b00}) begin errors++; $display("FAIL d6_head_wrap got %h exp %h", {cnt6, r6_tag, r6_vld}, {3'd2, 8'h98, 2'b00}); end
   endtask
   task automatic test_async_reset();
      #3;
      rstn = 1'b0;
      #1;
      checks++; if ({cnt8, e8, a8_tag, r8_tag} !== {4'd0, 1'b1, 8'h10, 8'h10}) begin errors++; $display("FAIL async_rst8 got %h", {cnt8, e8, a8_tag, r8_tag}); end
      checks++; if ({cnt6, e6, a6_tag, r6_tag} !== {3'd0, 1'b1, 8'h10, 8'h10}) begin errors++; $display("FAIL async_rst6 got %h", {cnt6, e6, a6_tag, r6_tag}); end
      cyc();
      rstn = 1'b1;
   endtask
   initial begin
      idle();
      test_reset();
      test_fill();
      test_order();
      test_wrap();
      test_flush();
      test_depth6();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/queue_retire_tracker.md
# queue_retire_tracker

Allocates queue tags at the tail and retires entries strictly in allocation order. Between those two points, completions arrive by tag in any order; an entry retires only once it and every older entry are complete. The block sits beside a multi-port queue or ROB-style buffer and produces the in-order dequeue fires that feed the queue's dequeue side. Tags carry a wrap flag bit so that stale tags can be detected after wrap-around.

## Interface
- Depth, 8: number of entries; any value ≥ 2, power of two not required.
- AllocWidth, 2: allocation lanes; ≤ Depth.
- CplWidth, 2: completion lanes.
- RetireWidth, 2: retire lanes; ≤ Depth.
- PtrWidth (local): $clog2(Depth). TagWidth (local): PtrWidth+1, MSB = wrap flag. CntWidth (local): $clog2(Depth+1).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- alloc_vld_i  in  AllocWidth  allocation requests; must be prefix-compacted (lane i set implies all lanes < i set).
- alloc_rdy_o  out  1  high when free entries ≥ AllocWidth.
- alloc_tag_o  out  AllocWidth×TagWidth  tag lane i receives if it fires; lane i = tail+i with wrap.
- cpl_vld_i  in  CplWidth  completion valids.
- cpl_tag_i  in  CplWidth×TagWidth  completed tags.
- retire_vld_o  out  RetireWidth  in-order retire candidates; always prefix-compacted.
- retire_tag_o  out  RetireWidth×TagWidth  lane i = head+i with wrap.
- retire_rdy_i  in  1  when high, all asserted retire_vld_o lanes fire.
- flush_i  in  1  synchronous flush.
- count_o  out  CntWidth  occupied entries.
- empty_o / full_o  out  1 each  count_o==0 / count_o==Depth.

## Operation
- State:
  - per-entry alloc_q, done_q, flag_q;
  - head_q and tail_q, each TagWidth;
  - count_q.
- Allocation:
  - Fires when alloc_rdy_o & alloc_vld_i; nalloc = popcount.
  - For each fired lane, the block sets alloc_q, clears done_q and writes flag_q at the lane's tag index.
  - tail advances by nalloc.
  - Requests while alloc_rdy_o is low are ignored.
- Wrap rule: index Depth-1 + 1 → index 0 with the flag inverted. Multi-step advance (tail or head + n) uses the same rule; it must not rely on natural binary overflow when Depth is not a power of two.
- Completion:
  - A lane sets done_q[idx] only if alloc_q[idx] is set and flag_q[idx] equals the tag flag.
  - Otherwise (stale or unallocated) it is ignored, with no error.
  - Duplicate completions are harmless. Two lanes carrying the same tag are harmless.
- Retire:
  - retire_vld_o[i] = AND over k≤i of (alloc_q & done_q) at head+k, and i < count_q.
  - On fire, the block clears alloc_q and done_q for the fired entries; head advances by nretire = popcount(retire_vld_o) when retire_rdy_i is high.
- Count: count_d = count_q + nalloc − nretire.
- Flush (priority over everything in that cycle):
  - clears all alloc_q and done_q;
  - sets head_q ← tail_q (flag included);
  - sets count_q ← 0;
  - ignores allocations, completions and retires in that cycle;
  - suppresses retire_vld_o to 0 in that cycle.
- Reset: head_q = tail_q = 0 (flag 0); all state bits 0; count 0.

## Timing
- All outputs are combinational from registered state only. The exception is retire_vld_o, which is additionally gated by flush_i. There is no combinational path from alloc_vld_i, cpl_* or retire_rdy_i to any output.
- Reset values:
  - alloc_rdy_o=1, empty_o=1, full_o=0, count_o=0;
  - retire_vld_o=0;
  - alloc_tag_o lane i = i;
  - retire_tag_o lane i = i.
- Latencies:
  - Allocate in cycle N → entry visible (count, tail) in N+1.
  - Complete in N → retire_vld_o can assert in N+1.
  - Completing and retiring the same entry in one cycle is impossible.
- alloc_rdy_o uses count_q only. Space freed by a retire in cycle N becomes usable in N+1.
- Simultaneous alloc + retire at count_q==Depth−AllocWidth is legal; count reflects both.
- Reset asserted mid-operation returns the block to the reset state immediately (asynchronously).

## Test plan
- Reset, then idle: count_o=0, empty_o=1, alloc_rdy_o=1, alloc_tag_o={1,0}, retire_vld_o=0.
- Depth=8, alloc 2/cycle for 4 cycles → tags 0..7 issued, count_o=8, full_o=1, alloc_rdy_o=0; a 5th request is ignored and tail is unchanged.
- Completion ordering:
  - Complete tags 3 and 1 → no retire.
  - Complete 0 → next cycle retire_vld_o=2'b11 with tags 0,1.
  - After those fire, tag 2 is not done → retire_vld_o=0.
  - Complete 2 → retire of 2 and 3.
- Wrap:
  - Cycle 12 allocations at 2/cycle with retire_rdy_i=1 → tags after index 7 come out as 8 (flag 1, idx 0) and upward.
  - A completion with tag 0 (flag 0) to a flag-1 entry is ignored.
- Depth=6: allocations wrap 5 → {1,0}. Same-cycle alloc 2 + retire 2 at count 4 keeps count 4.
- Flush with 5 live entries, a pending completion and retire_rdy_i=1:
  - next cycle count_o=0, empty_o=1, head=tail, retire_vld_o=0;
  - the completion in the flush cycle has no effect;
  - the next allocation receives the old tail tag.
